// File: rtl/codec_config_sequencer.sv
// rtl/codec_config_sequencer.sv - audio codec register init/update sequencer driving an I2C word master
module codec_config_sequencer #(
  parameter int STARTUP_CYCLES = 50000,
  parameter int RETRY_GAP      = 1000,
  parameter int MAX_RETRY      = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        upd_valid,
  input  logic [15:0] upd_word,
  output logic        upd_ready,
  output logic        i2c_go,
  output logic [15:0] i2c_word,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        cfg_done,
  output logic        cfg_error,
  output logic        dac_enable,
  output logic        busy
);

  localparam int DLY_MAX = (STARTUP_CYCLES > RETRY_GAP) ? STARTUP_CYCLES : RETRY_GAP;
  localparam int DW      = (DLY_MAX < 1) ? 1 : $clog2(DLY_MAX + 1);
  localparam int RW      = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [3:0] S_IDLE      = 4'd0;
  localparam logic [3:0] S_WAIT_PWR  = 4'd1;
  localparam logic [3:0] S_ISSUE     = 4'd2;
  localparam logic [3:0] S_WAIT_XFER = 4'd3;
  localparam logic [3:0] S_GAP       = 4'd4;
  localparam logic [3:0] S_READY     = 4'd5;
  localparam logic [3:0] S_UPD_ISSUE = 4'd6;
  localparam logic [3:0] S_UPD_WAIT  = 4'd7;
  localparam logic [3:0] S_ERROR     = 4'd8;

  localparam logic [3:0] LAST_IDX = 4'd8;

  logic [3:0]    state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [DW-1:0] dly_q, dly_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [15:0]   word_q, word_d;
  logic          upd_mode_q, upd_mode_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_error_q, cfg_error_d;

  logic [DW-1:0] dly_inc;
  logic [RW-1:0] retry_inc;
  logic          startup_done;
  logic          gap_done;
  logic          retry_hit;
  logic          restart;

  // Init table; the activate write must stay last so the codec only runs once fully configured.
  function automatic logic [15:0] rom_word(input logic [3:0] i);
    case (i)
      4'd0:    rom_word = 16'h1E00;
      4'd1:    rom_word = 16'h0C00;
      4'd2:    rom_word = 16'h0812;
      4'd3:    rom_word = 16'h0A00;
      4'd4:    rom_word = 16'h0E23;
      4'd5:    rom_word = 16'h102F;
      4'd6:    rom_word = 16'h0460;
      4'd7:    rom_word = 16'h0660;
      4'd8:    rom_word = 16'h1201;
      default: rom_word = 16'h0000;
    endcase
  endfunction

  // Saturating counter helpers and delay/retry completion terms.
  always_comb begin
    dly_inc      = (dly_q == DW'(DLY_MAX)) ? dly_q : dly_q + DW'(1);
    retry_inc    = (retry_q == RW'(MAX_RETRY)) ? retry_q : retry_q + RW'(1);
    startup_done = (32'(dly_q) + 32'd1) >= 32'(STARTUP_CYCLES);
    gap_done     = (32'(dly_q) + 32'd1) >= 32'(RETRY_GAP);
    retry_hit    = 32'(retry_inc) >= 32'(MAX_RETRY);
    restart      = cfg_start && ((state_q == S_IDLE) || (state_q == S_READY) || (state_q == S_ERROR));
  end

  // Next-state logic; a restart request outranks everything else, including a pending update.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    retry_d     = retry_q;
    word_d      = word_q;
    upd_mode_d  = upd_mode_q;
    cfg_done_d  = cfg_done_q;
    cfg_error_d = cfg_error_q;
    if (restart) begin
      state_d     = S_WAIT_PWR;
      idx_d       = 4'd0;
      dly_d       = '0;
      retry_d     = '0;
      upd_mode_d  = 1'b0;
      cfg_done_d  = 1'b0;
      cfg_error_d = 1'b0;
    end else begin
      case (state_q)
        S_WAIT_PWR: begin
          if (startup_done) begin
            state_d = S_ISSUE;
            dly_d   = '0;
            word_d  = rom_word(idx_q);
          end else begin
            dly_d = dly_inc;
          end
        end
        S_ISSUE:     state_d = S_WAIT_XFER;
        S_UPD_ISSUE: state_d = S_UPD_WAIT;
        S_WAIT_XFER, S_UPD_WAIT: begin
          if (i2c_done) begin
            if (!i2c_nack) begin
              retry_d = '0;
              if (state_q == S_UPD_WAIT) begin
                state_d    = S_READY;
                upd_mode_d = 1'b0;
              end else if (idx_q == LAST_IDX) begin
                state_d    = S_READY;
                cfg_done_d = 1'b1;
              end else begin
                state_d = S_ISSUE;
                idx_d   = idx_q + 4'd1;
                word_d  = rom_word(idx_q + 4'd1);
              end
            end else begin
              retry_d = retry_inc;
              dly_d   = '0;
              if (retry_hit) begin
                state_d     = S_ERROR;
                upd_mode_d  = 1'b0;
                cfg_done_d  = 1'b0;
                cfg_error_d = 1'b1;
              end else begin
                state_d = S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (gap_done) begin
            state_d = upd_mode_q ? S_UPD_ISSUE : S_ISSUE;
            dly_d   = '0;
          end else begin
            dly_d = dly_inc;
          end
        end
        S_READY: begin
          if (upd_valid) begin
            state_d    = S_UPD_ISSUE;
            word_d     = upd_word;
            upd_mode_d = 1'b1;
          end
        end
        S_IDLE, S_ERROR: state_d = state_q;
        default:         state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      dly_q       <= '0;
      retry_q     <= '0;
      word_q      <= 16'h0000;
      upd_mode_q  <= 1'b0;
      cfg_done_q  <= 1'b0;
      cfg_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      retry_q     <= retry_d;
      word_q      <= word_d;
      upd_mode_q  <= upd_mode_d;
      cfg_done_q  <= cfg_done_d;
      cfg_error_q <= cfg_error_d;
    end
  end

  assign i2c_go     = (state_q == S_ISSUE) || (state_q == S_UPD_ISSUE);
  assign i2c_word   = word_q;
  assign upd_ready  = (state_q == S_READY);
  assign cfg_done   = cfg_done_q;
  assign dac_enable = cfg_done_q;
  assign cfg_error  = cfg_error_q;
  assign busy       = !((state_q == S_IDLE) || (state_q == S_READY) || (state_q == S_ERROR));

endmodule
